// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial frame link: default geometry, FSM encoding and
// counter/parity helpers. PARITY_CHECK_EN adds one even-parity bit after every word.
package serial_link_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_WORDS = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int bits_per_word(input int width);
`ifdef PARITY_CHECK_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic logic word_parity(input logic [31:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Serial input and parallel-frame handshake bundle of the serial frame receiver.
// Counter widths follow PARITY_CHECK_EN through the shared package helpers.
interface serial_frame_receiver_if
  import serial_link_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_WORDS
);
  localparam int QB_W = cnt_w(bits_per_word(WIDTH));
  localparam int QW_W = cnt_w(WORDS);

  logic                   data;
  logic                   bit_valid;
  logic                   bit_first;
  logic                   out_ready;
  logic [WORDS*WIDTH-1:0] frame_out;
  logic                   out_valid;
  logic                   received_n;
  logic [QB_W-1:0]        qbit;
  logic [QW_W-1:0]        qword;
  logic                   sync_err;
  logic                   overrun;
  logic                   parity_err;

  modport master (
    output data, bit_valid, bit_first, out_ready,
    input  frame_out, out_valid, received_n, qbit, qword, sync_err, overrun, parity_err
  );

  modport slave (
    input  data, bit_valid, bit_first, out_ready,
    output frame_out, out_valid, received_n, qbit, qword, sync_err, overrun, parity_err
  );
endinterface

// File: rtl/sipo_shift_reg.sv
// Frame assembly register with single-bit indexed write; frame_next shows the
// contents including this cycle's write so completion can capture it on the same edge.
module sipo_shift_reg #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic             wr_clear,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_bit,
  output logic [N-1:0]     frame_next
);
  logic [N-1:0] q;

  // next contents: optional wipe (frame restart) plus the indexed bit write
  always_comb begin
    if (wr_en) begin
      frame_next         = wr_clear ? {N{1'b0}} : q;
      frame_next[wr_idx] = wr_bit;
    end else begin
      frame_next = q;
    end
  end

  // assembly storage
  always_ff @(posedge clk or posedge clr) begin
    if (clr) q <= {N{1'b0}};
    else     q <= frame_next;
  end
endmodule

// File: rtl/serial_frame_receiver.sv
// Rebuilds WORDS x WIDTH frames from a serial LSB-first bit stream and holds them on a
// registered valid/ready output. PARITY_CHECK_EN enables per-word even-parity checking.
module serial_frame_receiver
  import serial_link_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_WORDS
) (
  input logic                    clk,
  input logic                    clr,
  serial_frame_receiver_if.slave bus
);
  localparam int BPW   = bits_per_word(WIDTH);
  localparam int FW    = WIDTH * WORDS;
  localparam int QB_W  = cnt_w(BPW);
  localparam int QW_W  = cnt_w(WORDS);
  localparam int IDX_W = cnt_w(FW);
  localparam logic [QB_W-1:0] QBIT_LAST  = QB_W'(BPW - 1);
  localparam logic [QW_W-1:0] QWORD_LAST = QW_W'(WORDS - 1);

  state_t          state;
  logic [QB_W-1:0] qbit;
  logic [QW_W-1:0] qword;
  logic            err_acc;

  logic             restart;
  logic             data_pos;
  logic             last_bit;
  logic             wr_en;
  logic [IDX_W-1:0] word_base;
  logic [IDX_W-1:0] wr_idx;
  logic [FW-1:0]    frame_next;
  logic             par_bad;

  // write addressing; a bit_first always lands at word 0 bit 0 of a wiped frame
  always_comb begin
    restart   = bus.bit_valid & bus.bit_first;
    data_pos  = (int'(qbit) < WIDTH);
    last_bit  = (qword == QWORD_LAST) && (qbit == QBIT_LAST);
    wr_en     = restart | (bus.bit_valid & (state == RECV) & data_pos);
    word_base = IDX_W'(qword) * IDX_W'(WIDTH);
    wr_idx    = restart ? {IDX_W{1'b0}} : (word_base + IDX_W'(qbit));
  end

`ifdef PARITY_CHECK_EN
  logic [WIDTH-1:0] cur_word;

  // parity bit slot: no write this cycle, so frame_next holds the finished word
  always_comb begin
    cur_word = frame_next[word_base +: WIDTH];
    par_bad  = word_parity(32'(cur_word)) ^ bus.data;
  end
`else
  assign par_bad = 1'b0;
`endif

  sipo_shift_reg #(.N(FW), .IDX_W(IDX_W)) u_sipo (
    .clk        (clk),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_clear   (restart),
    .wr_idx     (wr_idx),
    .wr_bit     (bus.data),
    .frame_next (frame_next)
  );

  // receive FSM, counters, output register and handshake
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state          <= IDLE;
      qbit           <= {QB_W{1'b0}};
      qword          <= {QW_W{1'b0}};
      err_acc        <= 1'b0;
      bus.frame_out  <= {FW{1'b0}};
      bus.out_valid  <= 1'b0;
      bus.received_n <= 1'b1;
      bus.sync_err   <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      bus.sync_err <= 1'b0;
      bus.overrun  <= 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid  <= 1'b0;
        bus.received_n <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (restart) begin
            state   <= RECV;
            qbit    <= QB_W'(1);
            qword   <= {QW_W{1'b0}};
            err_acc <= 1'b0;
          end
        end
        RECV: begin
          if (restart) begin
            bus.sync_err <= 1'b1;
            qbit         <= QB_W'(1);
            qword        <= {QW_W{1'b0}};
            err_acc      <= 1'b0;
          end else if (bus.bit_valid) begin
            if (last_bit) begin
              state <= IDLE;
              qbit  <= {QB_W{1'b0}};
              qword <= {QW_W{1'b0}};
              if (bus.out_valid && !bus.out_ready) begin
                bus.overrun <= 1'b1;
              end else begin
                bus.frame_out  <= frame_next;
                bus.out_valid  <= 1'b1;
                bus.received_n <= 1'b0;
                bus.parity_err <= err_acc | par_bad;
              end
            end else if (qbit == QBIT_LAST) begin
              qbit    <= {QB_W{1'b0}};
              qword   <= qword + QW_W'(1);
              err_acc <= err_acc | par_bad;
            end else begin
              qbit <= qbit + QB_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.qbit  = qbit;
  assign bus.qword = qword;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed + randomized bench for serial_frame_receiver; bit stream and expected frame
// are derived arithmetically from the frame value (PARITY_CHECK_EN adds parity bits).
module tb_serial_frame_receiver;
  import serial_link_pkg::*;

  localparam int WIDTH = 4;
  localparam int WORDS = 4;
  localparam int FW    = WIDTH * WORDS;
`ifdef PARITY_CHECK_EN
  localparam int BPW = WIDTH + 1;
`else
  localparam int BPW = WIDTH;
`endif
  localparam int NBITS = WORDS * BPW;

  logic clk = 1'b0;
  logic clr;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  logic [FW-1:0] f1;
  logic [FW-1:0] f2;

  serial_frame_receiver_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

  serial_frame_receiver #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // first nbits of frame f: word k bit b is f[k*WIDTH+b]; parity slot carries even parity
  task automatic send_frame(input logic [FW-1:0] f, input int nbits, input int max_gap,
                            input int bad_word, input logic restart, input int ready_last);
    for (int n = 0; n < nbits; n++) begin
      int k;
      int b;
      k = n / BPW;
      b = n % BPW;
      if (b < WIDTH) bus.data = f[k*WIDTH+b];
      else           bus.data = (^f[k*WIDTH +: WIDTH]) ^ (k == bad_word);
      bus.bit_valid = 1'b1;
      bus.bit_first = (n == 0);
      if (n == NBITS - 1 && ready_last >= 0) bus.out_ready = ready_last[0];
      tick;
      bus.bit_valid = 1'b0;
      bus.bit_first = 1'b0;
      if (n == 0) begin
        chk("sync_err_first_bit", 32'(bus.sync_err), 32'(restart));
        if (restart) chk("restart_no_complete", 32'(bus.out_valid), 32'(1'b0));
      end
      if (n < NBITS - 1) begin
        chk("qbit", 32'(bus.qbit), 32'((n + 1) % BPW));
        chk("qword", 32'(bus.qword), 32'((n + 1) / BPW));
        repeat ($urandom_range(max_gap, 0)) begin
          tick;
          chk("qbit_hold", 32'(bus.qbit), 32'((n + 1) % BPW));
          chk("qword_hold", 32'(bus.qword), 32'((n + 1) / BPW));
        end
      end
    end
  endtask

  task automatic chk_done(input string tag, input logic [FW-1:0] f, input logic perr);
    chk({tag, "_frame"}, 32'(bus.frame_out), 32'(f));
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(1'b1));
    chk({tag, "_received_n"}, 32'(bus.received_n), 32'(1'b0));
    chk({tag, "_overrun"}, 32'(bus.overrun), 32'(1'b0));
    chk({tag, "_parity_err"}, 32'(bus.parity_err), 32'(perr));
  endtask

  initial begin
    bus.data      = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_first = 1'b0;
    bus.out_ready = 1'b1;
    clr           = 1'b1;
    tick;
    chk("rst_valid", 32'(bus.out_valid), 32'(1'b0));
    chk("rst_received_n", 32'(bus.received_n), 32'(1'b1));
    chk("rst_frame", 32'(bus.frame_out), 32'h0);
    chk("rst_qbit", 32'(bus.qbit), 32'h0);
    chk("rst_qword", 32'(bus.qword), 32'h0);
    chk("rst_pulses", 32'({bus.sync_err, bus.overrun, bus.parity_err}), 32'h0);
    clr = 1'b0;
    tick;

    // bit_valid without bit_first in IDLE is ignored
    bus.data      = 1'b1;
    bus.bit_valid = 1'b1;
    tick;
    bus.bit_valid = 1'b0;
    chk("idle_ignore_qbit", 32'(bus.qbit), 32'h0);
    chk("idle_ignore_valid", 32'(bus.out_valid), 32'(1'b0));

    // basic frame, consumed immediately
    send_frame(16'hF0C5, NBITS, 0, -1, 1'b0, -1);
    chk_done("t1", 16'hF0C5, 1'b0);
    tick;
    chk("t1_consumed", 32'(bus.out_valid), 32'(1'b0));
    chk("t1_received_n_back", 32'(bus.received_n), 32'(1'b1));

    // same frame with gaps
    send_frame(16'hF0C5, NBITS, 3, -1, 1'b0, -1);
    chk_done("t2", 16'hF0C5, 1'b0);
    tick;

    // random frames with random gaps
    repeat (4) begin
      f1 = FW'($urandom);
      send_frame(f1, NBITS, 2, -1, 1'b0, -1);
      chk_done("rand", f1, 1'b0);
      tick;
    end

    // overrun: held frame is kept while the next completes
    bus.out_ready = 1'b0;
    send_frame(16'hF0C5, NBITS, 0, -1, 1'b0, -1);
    chk_done("t3_first", 16'hF0C5, 1'b0);
    tick;
    chk("t3_hold", 32'(bus.out_valid), 32'(1'b1));
    send_frame(16'h1234, NBITS, 1, -1, 1'b0, -1);
    chk("t3_overrun", 32'(bus.overrun), 32'(1'b1));
    chk("t3_frame_kept", 32'(bus.frame_out), 32'hF0C5);
    chk("t3_valid_kept", 32'(bus.out_valid), 32'(1'b1));
    tick;
    chk("t3_overrun_pulse", 32'(bus.overrun), 32'(1'b0));
    bus.out_ready = 1'b1;
    tick;
    chk("t3_cleared", 32'(bus.out_valid), 32'(1'b0));

    // completion on the same edge the held frame is accepted overwrites it
    bus.out_ready = 1'b0;
    f1 = FW'($urandom);
    f2 = FW'($urandom);
    send_frame(f1, NBITS, 0, -1, 1'b0, -1);
    send_frame(f2, NBITS, 0, -1, 1'b0, 1);
    chk_done("overwrite", f2, 1'b0);
    tick;
    chk("overwrite_consumed", 32'(bus.out_valid), 32'(1'b0));

    // restart at word 2 bit 1
    send_frame(16'h3C96, 2 * BPW + 1, 1, -1, 1'b0, -1);
    send_frame(16'hA5A5, NBITS, 0, -1, 1'b1, -1);
    chk_done("t4", 16'hA5A5, 1'b0);
    tick;

    // bit_first on what would be the final bit restarts instead of completing
    f1 = FW'($urandom);
    f2 = FW'($urandom);
    send_frame(f1, NBITS - 1, 0, -1, 1'b0, -1);
    send_frame(f2, NBITS, 0, -1, 1'b1, -1);
    chk_done("last_restart", f2, 1'b0);
    tick;

    // asynchronous clear mid-frame
    send_frame(16'h5A3C, BPW + 2, 0, -1, 1'b0, -1);
    #2 clr = 1'b1;
    #1;
    chk("t5_frame", 32'(bus.frame_out), 32'h0);
    chk("t5_received_n", 32'(bus.received_n), 32'(1'b1));
    chk("t5_qbit", 32'(bus.qbit), 32'h0);
    chk("t5_qword", 32'(bus.qword), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    tick;
    f1 = FW'($urandom);
    send_frame(f1, NBITS, 1, -1, 1'b0, -1);
    chk_done("t5_after", f1, 1'b0);
    tick;

`ifdef PARITY_CHECK_EN
    send_frame(16'hF0C5, NBITS, 0, 1, 1'b0, -1);
    chk_done("t6_bad", 16'hF0C5, 1'b1);
    tick;
    send_frame(16'hF0C5, NBITS, 0, -1, 1'b0, -1);
    chk_done("t6_good", 16'hF0C5, 1'b0);
    tick;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
